// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one byte FIFO in front of a UART transmitter between NUM_REQ byte
//   sources. The push side is a round-robin frame arbiter: the winner keeps the
//   FIFO until it pushes a byte flagged last, so frames never interleave. The
//   pop side is a drain FSM. It moves one FIFO byte per UART character and
//   waits for the transmitter to go busy and then idle again.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i/data_i/last_i  per-requester byte stream (byte i at [8i+7:8i])
//   req_ready_o                per-requester accept (valid & ready)
//   fifo_push_o/push_data_o    FIFO write side, fifo_full_i back-pressure
//   fifo_pop_o, fifo_pop_data_i, fifo_empty_i   FIFO read side (head is combinational)
//   drain_en_i                 permits starting a new UART byte
//   tx_start_o, tx_data_o      one-cycle start pulse and held byte to the UART
//   tx_busy_i                  UART transmitting
//   gnt_valid_o, gnt_id_o      current frame owner (gnt_id_o keeps the last owner)
module uart_tx_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 fifo_push_o,
    output logic [7:0]           fifo_push_data_o,
    input  logic                 fifo_full_i,
    output logic                 fifo_pop_o,
    input  logic [7:0]           fifo_pop_data_i,
    input  logic                 fifo_empty_i,
    input  logic                 drain_en_i,
    output logic                 tx_start_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    output logic                 gnt_valid_o,
    output logic [IDW-1:0]       gnt_id_o
);

    typedef enum logic {A_IDLE, A_LOCK} arb_e;
    typedef enum logic [1:0] {D_IDLE, D_START, D_WAIT_BUSY, D_WAIT_DONE} drn_e;

    arb_e           arb_q;
    drn_e           drn_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] last_owner_q;
    logic           gnt_valid_q;
    logic           tx_start_q;
    logic [7:0]     tx_data_q;

    // ---------------- push side ----------------
    // Round-robin pick: scan from last_owner+1 upward (mod NUM_REQ). The loop
    // runs from the farthest candidate down to the nearest, so the nearest
    // valid requester writes last and wins.
    logic [IDW-1:0] win_id;
    logic           win_vld;
    int unsigned    idx;

    always_comb begin
        win_id  = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_owner_q) + k) % NUM_REQ;
            if (req_valid_i[idx]) begin
                win_id  = IDW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    logic locked;
    logic push_go;
    assign locked           = (arb_q == A_LOCK);
    assign push_go          = locked && req_valid_i[owner_q] && !fifo_full_i;
    assign fifo_push_o      = push_go;
    assign fifo_push_data_o = req_data_i[8*owner_q +: 8];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy
        assign req_ready_o[g] = locked && (owner_q == IDW'(g)) && !fifo_full_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arb_q        <= A_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDW'(NUM_REQ - 1);
            gnt_valid_q  <= 1'b0;
        end else begin
            case (arb_q)
                A_IDLE: if (win_vld) begin
                    owner_q     <= win_id;
                    gnt_valid_q <= 1'b1;
                    arb_q       <= A_LOCK;
                end
                A_LOCK: if (push_go && req_last_i[owner_q]) begin
                    last_owner_q <= owner_q;
                    gnt_valid_q  <= 1'b0;
                    arb_q        <= A_IDLE;
                end
                default: arb_q <= A_IDLE;
            endcase
        end
    end

    assign gnt_valid_o = gnt_valid_q;
    assign gnt_id_o    = owner_q;

    // ---------------- pop side ----------------
    // The pop is combinational so the FIFO head read in the same cycle is the
    // byte captured into tx_data_q.
    logic pop_go;
    assign pop_go     = (drn_q == D_IDLE) && drain_en_i && !fifo_empty_i && !tx_busy_i;
    assign fifo_pop_o = pop_go;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drn_q      <= D_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_start_q <= 1'b0;
            case (drn_q)
                D_IDLE: if (pop_go) begin
                    tx_data_q  <= fifo_pop_data_i;
                    tx_start_q <= 1'b1;
                    drn_q      <= D_START;
                end
                D_START:     drn_q <= D_WAIT_BUSY;
                // Wait for the UART to acknowledge and then finish the byte.
                // Only after that is a further pop allowed.
                D_WAIT_BUSY: if (tx_busy_i)  drn_q <= D_WAIT_DONE;
                D_WAIT_DONE: if (!tx_busy_i) drn_q <= D_IDLE;
                default:     drn_q <= D_IDLE;
            endcase
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
    localparam int NR = 3;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid, req_last, req_ready;
    logic [8*NR-1:0] req_data;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_push_data, fifo_pop_data, tx_data;
    logic            drain_en, tx_start, tx_busy, gnt_valid;
    logic [IW-1:0]   gnt_id;

    uart_tx_scheduler #(.NUM_REQ(NR), .IDW(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready),
        .fifo_push_o(fifo_push), .fifo_push_data_o(fifo_push_data), .fifo_full_i(fifo_full),
        .fifo_pop_o(fifo_pop), .fifo_pop_data_i(fifo_pop_data), .fifo_empty_i(fifo_empty),
        .drain_en_i(drain_en), .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
        .gnt_valid_o(gnt_valid), .gnt_id_o(gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int nchk = 0;
    int nerr = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- 16-entry FIFO environment ----------------
    logic [7:0] fmem [16];
    logic [3:0] wp, rp;
    int cnt = 0;
    int bad_push = 0;
    int bad_pop = 0;
    assign fifo_full     = (cnt == 16);
    assign fifo_empty    = (cnt == 0);
    assign fifo_pop_data = fmem[rp];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= 4'd0; rp <= 4'd0; cnt <= 0;
        end else begin
            if (fifo_push) begin
                if (cnt < 16) begin fmem[wp] <= fifo_push_data; wp <= wp + 4'd1; end
                else bad_push <= bad_push + 1;
            end
            if (fifo_pop) begin
                if (cnt > 0) rp <= rp + 4'd1;
                else bad_pop <= bad_pop + 1;
            end
            cnt <= cnt + ((fifo_push && cnt < 16) ? 1 : 0) - ((fifo_pop && cnt > 0) ? 1 : 0);
        end
    end

    // ---------------- UART busy environment ----------------
    int bcnt = 0;
    int busy_len = 10;
    assign tx_busy = (bcnt != 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bcnt <= 0;
        else if (bcnt != 0)  bcnt <= bcnt - 1;
        else if (tx_start)   bcnt <= busy_len;
    end

    // ---------------- requesters: queue of {last, data} ----------------
    logic [8:0] src_q [NR][$];
    logic [8:0] exp_q [NR][$];
    int stall_pct = 0;

    task automatic load_byte(input int r, input logic [7:0] d, input logic l);
        src_q[r].push_back({l, d});
    endtask

    initial begin
        logic [NR-1:0] acc;
        logic [8:0]    hd;
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && src_q[i].size() > 0) hd = src_q[i].pop_front();
                if (src_q[i].size() > 0 && $urandom_range(99) >= stall_pct) begin
                    hd = src_q[i][0];
                    req_valid[i] = 1'b1;
                    req_last[i]  = hd[8];
                    req_data[8*i +: 8] = hd[7:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [7:0] obs_q[$];
    int   nstart = 0;
    int   long_start = 0;
    logic prev_start = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (tx_start === 1'b1) begin
                obs_q.push_back(tx_data);
                nstart++;
                if (prev_start) long_start++;
            end
            prev_start = tx_start;
        end else prev_start = 1'b0;
    end

    task automatic wait_out(input int n, input int budget);
        int c = 0;
        while (obs_q.size() < n && c < budget) begin @(negedge clk); c++; end
        chk("wait_out", obs_q.size(), n);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((tx_busy || tx_start || cnt != 0) && c < 3000) begin @(negedge clk); c++; end
        chk("idle", {29'd0, tx_start, tx_busy, (cnt != 0)}, 0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] e3 [4];
        int c, total, cur, id;
        logic [8:0] e;
        logic [5:0] seq;

        rst_n = 1'b0; drain_en = 1'b0;
        // Two requesters already holding frames while reset is low.
        load_byte(0, 8'h10, 1'b0); load_byte(0, 8'h11, 1'b1);
        load_byte(1, 8'h20, 1'b0); load_byte(1, 8'h21, 1'b1);
        repeat (4) @(negedge clk);
        chk("rst_req_active", 32'(req_valid), 32'(3'b011));
        chk("rst_gnt_valid", gnt_valid, 0);
        chk("rst_gnt_id",    gnt_id, 0);
        chk("rst_tx_start",  tx_start, 0);
        chk("rst_tx_data",   tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fifo_push", fifo_push, 0);
        chk("rst_fifo_pop",  fifo_pop, 0);

        // Arbitration from reset: last_owner=NR-1, so the scan starts at req0.
        rst_n = 1'b1; drain_en = 1'b1;
        @(negedge clk);
        chk("t3_gnt_valid", gnt_valid, 1);
        chk("t3_first_owner", gnt_id, 0);
        wait_out(4, 200);
        e3 = '{8'h10, 8'h11, 8'h20, 8'h21};
        for (int i = 0; i < 4; i++) chk("t3_order", obs_q[i], e3[i]);
        // Wrap-around: last_owner=1, so req2 beats req0.
        wait_idle();
        obs_q.delete();
        load_byte(0, 8'h30, 1'b1);
        load_byte(2, 8'h31, 1'b1);
        wait_out(2, 200);
        chk("t3_wrap0", obs_q[0], 8'h31);
        chk("t3_wrap1", obs_q[1], 8'h30);

        // Single frame, grant latency, three start pulses.
        wait_idle();
        obs_q.delete();
        c = nstart;
        load_byte(0, 8'h41, 1'b0); load_byte(0, 8'h42, 1'b0); load_byte(0, 8'h43, 1'b1);
        @(negedge clk);
        chk("t2_no_gnt_same_cycle", gnt_valid, 0);
        @(negedge clk);
        chk("t2_gnt_valid", gnt_valid, 1);
        chk("t2_gnt_id", gnt_id, 0);
        chk("t2_none_taken_idle", src_q[0].size(), 3);
        wait_out(3, 200);
        chk("t2_b0", obs_q[0], 8'h41);
        chk("t2_b1", obs_q[1], 8'h42);
        chk("t2_b2", obs_q[2], 8'h43);
        wait_idle();
        chk("t2_starts", nstart - c, 3);

        // FIFO full back-pressure with drain disabled.
        obs_q.delete();
        drain_en = 1'b0;
        for (int k = 0; k < 17; k++) load_byte(0, 8'h80 + 8'(k), (k == 16));
        repeat (30) @(negedge clk);
        chk("t4_cnt", cnt, 16);
        chk("t4_full", fifo_full, 1);
        chk("t4_ready", req_ready[0], 0);
        chk("t4_pending", src_q[0].size(), 1);
        chk("t4_no_start", obs_q.size(), 0);
        drain_en = 1'b1;
        wait_out(17, 17 * 14 + 60);
        chk("t4_17th_taken", src_q[0].size(), 0);
        for (int k = 0; k < 17; k++) chk("t4_order", obs_q[k], 8'h80 + 8'(k));

        // Push and pop in the same cycle with one byte stored.
        wait_idle();
        obs_q.delete();
        drain_en = 1'b0; busy_len = 3;
        load_byte(0, 8'h50, 1'b0); load_byte(0, 8'h51, 1'b0); load_byte(0, 8'h52, 1'b1);
        c = 0;
        while (cnt != 1 && c < 20) begin @(negedge clk); c++; end
        chk("t5_one_stored", cnt, 1);
        drain_en = 1'b1;
        #1;
        chk("t5_push_pop", {30'd0, fifo_push, fifo_pop}, 2'b11);
        @(negedge clk);
        chk("t5_cnt_kept", cnt, 1);
        wait_out(3, 100);
        chk("t5_b0", obs_q[0], 8'h50);
        chk("t5_b1", obs_q[1], 8'h51);
        chk("t5_b2", obs_q[2], 8'h52);

        // Asynchronous reset while a byte is in flight and a frame is open.
        wait_idle();
        obs_q.delete();
        busy_len = 20;
        for (int k = 0; k < 30; k++) load_byte(1, 8'hC0 + 8'(k), (k == 29));
        c = 0;
        while (!tx_busy && c < 40) begin @(negedge clk); c++; end
        repeat (2) @(negedge clk);
        chk("t6_pre_busy", tx_busy, 1);
        chk("t6_pre_gnt", gnt_valid, 1);
        chk("t6_pre_id", gnt_id, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tx_start", tx_start, 0);
        chk("t6_gnt_valid", gnt_valid, 0);
        chk("t6_gnt_id", gnt_id, 0);
        chk("t6_tx_data", tx_data, 0);
        chk("t6_req_ready", req_ready, 0);
        chk("t6_push", fifo_push, 0);
        chk("t6_pop", fifo_pop, 0);
        for (int i = 0; i < NR; i++) src_q[i].delete();
        obs_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomized frames from all requesters; data carries {id, sequence}.
        stall_pct = 30;
        total = 0;
        for (int i = 0; i < NR; i++) begin
            seq = 6'd0;
            for (int f = 0; f < 6; f++) begin
                int len;
                len = $urandom_range(1, 5);
                for (int b = 0; b < len; b++) begin
                    e = {(b == len - 1), 2'(i), seq};
                    src_q[i].push_back(e);
                    exp_q[i].push_back(e);
                    seq = seq + 6'd1;
                    total++;
                end
            end
        end
        c = 0;
        while (obs_q.size() < total && c < 8000) begin
            @(negedge clk);
            drain_en = ($urandom_range(99) < 85);
            if ($urandom_range(9) == 0) busy_len = $urandom_range(1, 6);
            c++;
        end
        chk("rnd_count", obs_q.size(), total);
        // Each frame must appear whole and in per-requester order.
        cur = -1;
        for (int k = 0; k < obs_q.size(); k++) begin
            id = int'(obs_q[k][7:6]);
            if (cur >= 0) chk("rnd_interleave", id, cur);
            else cur = id;
            if (id < NR && exp_q[id].size() > 0) begin
                e = exp_q[id].pop_front();
                chk("rnd_data", obs_q[k], e[7:0]);
                if (e[8]) cur = -1;
            end else chk("rnd_unexpected", obs_q[k], 8'hFF);
        end
        drain_en = 1'b1;
        wait_idle();
        chk("no_push_when_full", bad_push, 0);
        chk("no_pop_when_empty", bad_pop, 0);
        chk("start_one_cycle", long_start, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
